ser_data_receiver: RTL and testbench

//  Serial (UART-style, 8N1, LSB first) receiver; receive-side counterpart of ser_data_sender.

---
 rtl/ser_data_receiver.sv | 151 +++++++++++++++
 tb/tb_ser_data_receiver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ser_data_receiver.sv
// rtl/ser_data_receiver.sv - 8N1 LSB-first serial receiver with mid-bit sampling
module ser_data_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_done_q, rx_done_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

    // Next-state logic: synchroniser shift, frame FSM, counters and output strobes
    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        // A start bit that is high again at its midpoint is a glitch
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s_q;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start bit counts
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
        end
    end

endmodule

// File: tb/tb_ser_data_receiver.sv
// tb/tb_ser_data_receiver.sv - scoreboard bench for ser_data_receiver
module tb_ser_data_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lat_start;
    } exp_t;

    exp_t exp_q[$];

    ser_data_receiver #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT strobes a result
    always @(negedge clk) begin
        if (rx_done && frame_err) begin
            chk("done_and_err_together", 1, 0);
        end else if (rx_done || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {rx_done, frame_err}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind_is_err", frame_err, e.is_err);
                chk("rx_data", rx_data, e.data);
                if (e.lat_start >= 0) begin
                    checks++;
                    if ((cyc - e.lat_start) < 154 || (cyc - e.lat_start) > 156) begin
                        errors++;
                        $display("FAIL latency actual %0d required 154..156", cyc - e.lat_start);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b, input bit expect_ok, input bit chk_lat);
        exp_t e;
        if (expect_ok) begin
            e.is_err    = 1'b0;
            e.data      = d;
            e.lat_start = chk_lat ? cyc : -1;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // Start a frame of zeros and stop eight cycles into data bit 4
    task automatic partial_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        repeat (CPB / 2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'h0F, 1'b1, 1'b1, 1'b1);
        wait_drain("drain_0f");
        chk("hold_0f", rx_data, 8'h0F);
        repeat (10) @(negedge clk);

        send_byte(8'hAA, 1'b1, 1'b1, 1'b0);
        send_byte(8'hEE, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_aa_ee");
        repeat (10) @(negedge clk);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_in_start", busy, 1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_dropped", busy, 0);
        chk("glitch_rx_data", rx_data, 8'hEE);

        e.is_err = 1'b1; e.data = 8'hEE; e.lat_start = -1;
        exp_q.push_back(e);
        send_byte(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("break_busy_held", busy, 1);
        chk("break_rx_data", rx_data, 8'hEE);
        wait_drain("drain_ferr");
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("break_busy_released", busy, 0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_3c");
        repeat (10) @(negedge clk);

        partial_frame();
        chk("en_abort_busy_before", busy, 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_abort_busy_after", busy, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("en_abort_rx_data", rx_data, 8'h3C);
        send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_c3_en");
        repeat (10) @(negedge clk);

        partial_frame();
        chk("rst_abort_busy_before", busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_abort_busy_after", busy, 0);
        chk("rst_abort_rx_data", rx_data, 8'h00);
        repeat (12 * CPB) @(negedge clk);
        send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_c3_rst");
        chk("final_rx_data", rx_data, 8'hC3);
        repeat (20) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
